// File: rtl/hilo_stage.sv
// ----------------------------------------------------------------------------
// hilo_stage
//
// Execute-to-memory HI/LO stage sitting directly behind the ALU. It captures
// the ALU's 64-bit HI/LO result and write select into an E/M pipeline
// register. It commits that entry into the architectural HI and LO
// registers on the edge where it leaves M, provided it raised no exception.
// It also forwards the freshest HI/LO value back to E so that an MFHI/MFLO
// directly behind a writer sees the new value without waiting.
//
// Ports:
//   clk           in   1   rising-edge clock
//   rst           in   1   asynchronous active-low reset
//   hilo_writeE   in   1   HI/LO write request for the instruction in E
//   hilo_selectE  in   2   00 both, 11 HI only, 10 LO only, 01 no write
//   aluoutE       in  64   ALU result {HI, LO}
//   stallM        in   1   hold the M stage
//   flushM        in   1   squash the M stage entry
//   exceptM       in   1   instruction in M excepted; suppress its commit
//   hiE           out 32   forwarded HI for E-stage MFHI
//   loE           out 32   forwarded LO for E-stage MFLO
//   hilo_busyM    out  1   M holds a live, uncommitted HI/LO write
//   hi_o          out 32   architectural HI
//   lo_o          out 32   architectural LO
// ----------------------------------------------------------------------------
module hilo_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        hilo_writeE,
    input  logic [1:0]  hilo_selectE,
    input  logic [63:0] aluoutE,
    input  logic        stallM,
    input  logic        flushM,
    input  logic        exceptM,
    output logic [31:0] hiE,
    output logic [31:0] loE,
    output logic        hilo_busyM,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    // Write-select encodings as produced by the ALU.
    typedef enum logic [1:0] {
        SelBoth     = 2'b00,
        SelReserved = 2'b01,
        SelLo       = 2'b10,
        SelHi       = 2'b11
    } hiloSelT;

    // M-stage pipeline register.
    logic        validM_q, validM_d;
    hiloSelT     selM_q,   selM_d;
    logic [63:0] dataM_q,  dataM_d;

    // Architectural HI/LO.
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Decoded view of the entry sitting in M.
    logic        live;
    logic        commitEn;
    logic        selWritesHi;
    logic        selWritesLo;
    hiloSelT     selE;

    assign selE = hiloSelT'(hilo_selectE);

    // An entry is live only if it is valid and its instruction did not
    // except; an excepted entry must never become visible or commit.
    assign live     = validM_q & ~exceptM;
    assign commitEn = live & ~stallM & ~flushM;

    // Per-half decode of the M entry's select.
    always_comb begin
        selWritesHi = 1'b0;
        selWritesLo = 1'b0;
        case (selM_q)
            SelBoth: begin
                selWritesHi = 1'b1;
                selWritesLo = 1'b1;
            end
            SelHi:       selWritesHi = 1'b1;
            SelLo:       selWritesLo = 1'b1;
            SelReserved: ;
            default:     ;
        endcase
    end

    // M-register next state: flush beats stall, stall beats capture. A
    // reserved select is captured as an invalid entry so it never commits
    // or forwards.
    always_comb begin
        validM_d = validM_q;
        selM_d   = selM_q;
        dataM_d  = dataM_q;
        if (flushM) begin
            validM_d = 1'b0;
        end else if (!stallM) begin
            validM_d = hilo_writeE & (selE != SelReserved);
            selM_d   = selE;
            dataM_d  = aluoutE;
        end
    end

    // Architectural next state: the M entry commits only on the edge it
    // actually leaves M. Halves not selected keep their old value.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commitEn) begin
            if (selWritesHi) begin
                hi_d = dataM_q[63:32];
            end
            if (selWritesLo) begin
                lo_d = dataM_q[31:0];
            end
        end
    end

    // State registers. Reset discards any pending entry without committing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validM_q <= 1'b0;
            selM_q   <= SelBoth;
            dataM_q  <= 64'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            validM_q <= validM_d;
            selM_q   <= selM_d;
            dataM_q  <= dataM_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Forwarding merges per half: a partial write only overrides the half
    // it targets, the other half comes from architectural state.
    assign hiE        = (live & selWritesHi) ? dataM_q[63:32] : hi_q;
    assign loE        = (live & selWritesLo) ? dataM_q[31:0]  : lo_q;
    assign hilo_busyM = live;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_hilo_stage.sv
// ----------------------------------------------------------------------------
// tb_hilo_stage
//
// Self-checking bench for hilo_stage. Each scenario task drives stimulus and
// compares outputs inline. Expected architectural {HI, LO} values are pushed
// onto a scoreboard queue when a committing write is driven and popped when
// the commit edge has passed.
// ----------------------------------------------------------------------------
module tb_hilo_stage;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hiloT;

    logic        clk;
    logic        rst;
    logic        hiloWriteE;
    logic [1:0]  hiloSelectE;
    logic [63:0] aluoutE;
    logic        stallM;
    logic        flushM;
    logic        exceptM;
    logic [31:0] hiE;
    logic [31:0] loE;
    logic        hiloBusyM;
    logic [31:0] hiO;
    logic [31:0] loO;

    int   checkCount = 0;
    int   passCount  = 0;
    hiloT expQ[$];
    hiloT exp;

    hilo_stage dut (
        .clk          (clk),
        .rst          (rst),
        .hilo_writeE  (hiloWriteE),
        .hilo_selectE (hiloSelectE),
        .aluoutE      (aluoutE),
        .stallM       (stallM),
        .flushM       (flushM),
        .exceptM      (exceptM),
        .hiE          (hiE),
        .loE          (loE),
        .hilo_busyM   (hiloBusyM),
        .hi_o         (hiO),
        .lo_o         (loO)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard bound on total run time.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        hiloWriteE  = 1'b0;
        hiloSelectE = 2'b00;
        aluoutE     = 64'd0;
        stallM      = 1'b0;
        flushM      = 1'b0;
        exceptM     = 1'b0;
    endtask

    task automatic driveWrite(input logic [1:0] sel, input logic [63:0] data);
        hiloWriteE  = 1'b1;
        hiloSelectE = sel;
        aluoutE     = data;
    endtask

    // Outputs are zero while reset is held and on the first edge after release.
    task automatic test_reset();
        rst = 1'b0;
        idleInputs();
        #3;
        checkCount++;
        if ({hiE, loE, hiO, loO, hiloBusyM} !== 129'd0) $display("[TB] FAIL reset_async: got %h, required 0", {hiE, loE, hiO, loO, hiloBusyM});
        else passCount++;
        step();
        step();
        rst = 1'b1;
        step();
        checkCount++;
        if ({hiO, loO} !== 64'd0) $display("[TB] FAIL reset_release_arch: got %h, required 0", {hiO, loO});
        else passCount++;
        checkCount++;
        if ({hiE, loE, hiloBusyM} !== 65'd0) $display("[TB] FAIL reset_release_fwd: got %h, required 0", {hiE, loE, hiloBusyM});
        else passCount++;
    endtask

    // Both-halves write: forwarded one edge after E, committed one edge later.
    task automatic test_both_write();
        driveWrite(2'b00, 64'h11112222_33334444);
        expQ.push_back('{hi: 32'h11112222, lo: 32'h33334444});
        step();
        idleInputs();
        #1;
        checkCount++;
        if (hiE !== 32'h11112222) $display("[TB] FAIL both_fwd_hi: got %h, required 11112222", hiE);
        else passCount++;
        checkCount++;
        if (loE !== 32'h33334444) $display("[TB] FAIL both_fwd_lo: got %h, required 33334444", loE);
        else passCount++;
        checkCount++;
        if (hiloBusyM !== 1'b1) $display("[TB] FAIL both_busy: got %b, required 1", hiloBusyM);
        else passCount++;
        checkCount++;
        if ({hiO, loO} !== 64'd0) $display("[TB] FAIL both_early_commit: got %h, required 0", {hiO, loO});
        else passCount++;
        step();
        checkCount++;
        if (expQ.size() == 0) $display("[TB] FAIL both_commit: scoreboard empty, required an entry");
        else begin
            exp = expQ.pop_front();
            if ({hiO, loO} !== {exp.hi, exp.lo}) $display("[TB] FAIL both_commit: got %h, required %h", {hiO, loO}, {exp.hi, exp.lo});
            else passCount++;
        end
        checkCount++;
        if (hiloBusyM !== 1'b0) $display("[TB] FAIL both_busy_clear: got %b, required 0", hiloBusyM);
        else passCount++;
    endtask

    // Partial LO write leaves HI alone; forwarding merges per half.
    task automatic test_partial();
        driveWrite(2'b00, 64'hAAAA0000_0000BBBB);
        expQ.push_back('{hi: 32'hAAAA0000, lo: 32'h0000BBBB});
        step();
        idleInputs();
        step();
        checkCount++;
        if (expQ.size() == 0) $display("[TB] FAIL partial_setup: scoreboard empty, required an entry");
        else begin
            exp = expQ.pop_front();
            if ({hiO, loO} !== {exp.hi, exp.lo}) $display("[TB] FAIL partial_setup: got %h, required %h", {hiO, loO}, {exp.hi, exp.lo});
            else passCount++;
        end
        driveWrite(2'b10, 64'hFFFFFFFF_12345678);
        expQ.push_back('{hi: 32'hAAAA0000, lo: 32'h12345678});
        step();
        idleInputs();
        #1;
        checkCount++;
        if ({hiE, loE} !== 64'hAAAA0000_12345678) $display("[TB] FAIL partial_fwd: got %h, required AAAA000012345678", {hiE, loE});
        else passCount++;
        step();
        checkCount++;
        if (expQ.size() == 0) $display("[TB] FAIL partial_commit: scoreboard empty, required an entry");
        else begin
            exp = expQ.pop_front();
            if ({hiO, loO} !== {exp.hi, exp.lo}) $display("[TB] FAIL partial_commit: got %h, required %h", {hiO, loO}, {exp.hi, exp.lo});
            else passCount++;
        end
    endtask

    // Stalled entry forwards throughout and commits only when the stall drops.
    task automatic test_stall();
        driveWrite(2'b00, 64'h55556666_77778888);
        expQ.push_back('{hi: 32'h55556666, lo: 32'h77778888});
        step();
        idleInputs();
        stallM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkCount++;
            if ({hiO, loO} !== 64'hAAAA0000_12345678) $display("[TB] FAIL stall_no_commit[%0d]: got %h, required AAAA000012345678", i, {hiO, loO});
            else passCount++;
            checkCount++;
            if ({hiE, loE, hiloBusyM} !== {64'h55556666_77778888, 1'b1}) $display("[TB] FAIL stall_fwd[%0d]: got %h, required %h", i, {hiE, loE, hiloBusyM}, {64'h55556666_77778888, 1'b1});
            else passCount++;
        end
        stallM = 1'b0;
        step();
        checkCount++;
        if (expQ.size() == 0) $display("[TB] FAIL stall_commit: scoreboard empty, required an entry");
        else begin
            exp = expQ.pop_front();
            if ({hiO, loO} !== {exp.hi, exp.lo}) $display("[TB] FAIL stall_commit: got %h, required %h", {hiO, loO}, {exp.hi, exp.lo});
            else passCount++;
        end
    endtask

    // Excepted entry never forwards or commits; flush removes it.
    task automatic test_exception();
        driveWrite(2'b00, 64'hDEADBEEF_CAFEF00D);
        step();
        idleInputs();
        exceptM = 1'b1;
        stallM  = 1'b1;
        #1;
        checkCount++;
        if ({hiE, loE, hiloBusyM} !== {64'h55556666_77778888, 1'b0}) $display("[TB] FAIL except_fwd: got %h, required %h", {hiE, loE, hiloBusyM}, {64'h55556666_77778888, 1'b0});
        else passCount++;
        step();
        flushM = 1'b1;
        step();
        idleInputs();
        step();
        checkCount++;
        if ({hiO, loO} !== 64'h55556666_77778888) $display("[TB] FAIL except_no_commit: got %h, required 5555666677778888", {hiO, loO});
        else passCount++;
        checkCount++;
        if ({hiE, loE, hiloBusyM} !== {64'h55556666_77778888, 1'b0}) $display("[TB] FAIL except_after_flush: got %h, required %h", {hiE, loE, hiloBusyM}, {64'h55556666_77778888, 1'b0});
        else passCount++;
        // Exception without stall: no commit, entry replaced by the E capture.
        driveWrite(2'b00, 64'h01010101_02020202);
        step();
        driveWrite(2'b11, 64'h0A0A0A0A_0B0B0B0B);
        exceptM = 1'b1;
        expQ.push_back('{hi: 32'h0A0A0A0A, lo: 32'h77778888});
        step();
        idleInputs();
        #1;
        checkCount++;
        if ({hiO, loO} !== 64'h55556666_77778888) $display("[TB] FAIL except_replace_arch: got %h, required 5555666677778888", {hiO, loO});
        else passCount++;
        checkCount++;
        if ({hiE, loE} !== 64'h0A0A0A0A_77778888) $display("[TB] FAIL except_replace_fwd: got %h, required 0A0A0A0A77778888", {hiE, loE});
        else passCount++;
        step();
        checkCount++;
        if (expQ.size() == 0) $display("[TB] FAIL except_replace_commit: scoreboard empty, required an entry");
        else begin
            exp = expQ.pop_front();
            if ({hiO, loO} !== {exp.hi, exp.lo}) $display("[TB] FAIL except_replace_commit: got %h, required %h", {hiO, loO}, {exp.hi, exp.lo});
            else passCount++;
        end
    endtask

    // Consecutive writes, flush+stall together, and the reserved select.
    task automatic test_back_to_back();
        driveWrite(2'b00, 64'h00000001_00000001);
        expQ.push_back('{hi: 32'h00000001, lo: 32'h00000001});
        step();
        driveWrite(2'b11, 64'h00000002_00000099);
        expQ.push_back('{hi: 32'h00000002, lo: 32'h00000001});
        step();
        idleInputs();
        #1;
        checkCount++;
        if (expQ.size() == 0) $display("[TB] FAIL b2b_first: scoreboard empty, required an entry");
        else begin
            exp = expQ.pop_front();
            if ({hiO, loO} !== {exp.hi, exp.lo}) $display("[TB] FAIL b2b_first: got %h, required %h", {hiO, loO}, {exp.hi, exp.lo});
            else passCount++;
        end
        checkCount++;
        if ({hiE, loE} !== 64'h00000002_00000001) $display("[TB] FAIL b2b_fwd: got %h, required 0000000200000001", {hiE, loE});
        else passCount++;
        step();
        checkCount++;
        if (expQ.size() == 0) $display("[TB] FAIL b2b_second: scoreboard empty, required an entry");
        else begin
            exp = expQ.pop_front();
            if ({hiO, loO} !== {exp.hi, exp.lo}) $display("[TB] FAIL b2b_second: got %h, required %h", {hiO, loO}, {exp.hi, exp.lo});
            else passCount++;
        end
        // Flush together with stall: flush wins, nothing commits.
        driveWrite(2'b00, 64'h77777777_66666666);
        step();
        idleInputs();
        flushM = 1'b1;
        stallM = 1'b1;
        step();
        idleInputs();
        #1;
        checkCount++;
        if ({hiO, loO, hiloBusyM} !== {64'h00000002_00000001, 1'b0}) $display("[TB] FAIL flush_stall: got %h, required %h", {hiO, loO, hiloBusyM}, {64'h00000002_00000001, 1'b0});
        else passCount++;
        // Reserved select behaves as no write.
        driveWrite(2'b01, 64'h12121212_34343434);
        step();
        idleInputs();
        #1;
        checkCount++;
        if (hiloBusyM !== 1'b0) $display("[TB] FAIL reserved_busy: got %b, required 0", hiloBusyM);
        else passCount++;
        step();
        checkCount++;
        if ({hiO, loO} !== 64'h00000002_00000001) $display("[TB] FAIL reserved_no_commit: got %h, required 0000000200000001", {hiO, loO});
        else passCount++;
    endtask

    // Reset while a write is stalled in M discards it without committing.
    task automatic test_reset_mid_stall();
        driveWrite(2'b00, 64'h9999AAAA_BBBBCCCC);
        step();
        idleInputs();
        stallM = 1'b1;
        step();
        #2;
        rst = 1'b0;
        #1;
        checkCount++;
        if ({hiE, loE, hiO, loO, hiloBusyM} !== 129'd0) $display("[TB] FAIL midstall_reset: got %h, required 0", {hiE, loE, hiO, loO, hiloBusyM});
        else passCount++;
        step();
        rst    = 1'b1;
        stallM = 1'b0;
        step();
        step();
        checkCount++;
        if ({hiE, loE, hiO, loO, hiloBusyM} !== 129'd0) $display("[TB] FAIL midstall_after_release: got %h, required 0", {hiE, loE, hiO, loO, hiloBusyM});
        else passCount++;
        checkCount++;
        if (expQ.size() != 0) $display("[TB] FAIL scoreboard_drain: got %0d entries, required 0", expQ.size());
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_both_write();
        test_partial();
        test_stall();
        test_exception();
        test_back_to_back();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
